interval_fill: RTL and testbench

Scanline span filler; the consumer side of the interval shape modules. After a start pulse it walks scanlines y_top..y_bot. For each line it drives a query y to an interval shape module and reads back that module's [s, t] span. It then emits one pixel write per x in the span over a valid/ready stream toward the framebuffer writer. An interval with s > t is the shape modules' empty-line encoding; it produces no pixels.

---
 rtl/interval_fill.sv | 142 ++++++++++++++
 tb/tb_interval_fill.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_fill.sv
// interval_fill: scanline span filler feeding a valid/ready pixel stream.
// Optional clipping to H_RES columns is enabled by INTERVAL_FILL_CLIP_EN.
module interval_fill #(
  parameter int CORDW = 9,
  parameter int H_RES = 320
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CORDW-1:0] y_top,
  input  logic [CORDW-1:0] y_bot,
  output logic             busy,
  output logic             done,
  output logic [CORDW-1:0] query_y,
  input  logic [CORDW-1:0] s,
  input  logic [CORDW-1:0] t,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [CORDW-1:0] pix_x,
  output logic [CORDW-1:0] pix_y
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SPAN,
    DONE
  } state_t;

  localparam logic [CORDW-1:0] ONE  = CORDW'(1);
  localparam logic [CORDW-1:0] XMAX = CORDW'(H_RES - 1);

  state_t           state_q;
  logic [CORDW-1:0] y_q;
  logic [CORDW-1:0] ybot_q;
  logic [CORDW-1:0] x_q;
  logic [CORDW-1:0] xe_q;
  logic             busy_q;
  logic             done_q;
  logic             pix_valid_q;

  logic             empty_d;
  logic [CORDW-1:0] xe_d;
  logic             last_line;

`ifdef INTERVAL_FILL_CLIP_EN
  // Clip the span to the visible columns while the interval is loaded.
  always_comb begin
    empty_d = (s > t) || (s > XMAX);
    xe_d    = (t > XMAX) ? XMAX : t;
  end
`else
  // Spans pass through untouched; H_RES only matters when clipping.
  always_comb begin
    empty_d = (s > t);
    xe_d    = t;
  end

  logic unused_hres;
  assign unused_hres = ^XMAX;
`endif

  assign last_line = (y_q == ybot_q);

  // Fill sequencer: walks lines, loads spans, streams pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      y_q         <= '0;
      ybot_q      <= '0;
      x_q         <= '0;
      xe_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            y_q    <= y_top;
            ybot_q <= y_bot;
            busy_q <= 1'b1;
            if (y_top > y_bot) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          xe_q <= xe_d;
          if (empty_d) begin
            if (last_line) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              y_q     <= y_q + ONE;
              state_q <= LOAD;
            end
          end else begin
            x_q         <= s;
            pix_valid_q <= 1'b1;
            state_q     <= SPAN;
          end
        end
        SPAN: begin
          if (pix_ready) begin
            if (x_q == xe_q) begin
              pix_valid_q <= 1'b0;
              if (last_line) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                y_q     <= y_q + ONE;
                state_q <= LOAD;
              end
            end else begin
              x_q <= x_q + ONE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_valid = pix_valid_q;
  assign query_y   = y_q;
  assign pix_x     = x_q;
  assign pix_y     = y_q;

endmodule

// File: tb/tb_interval_fill.sv
// Directed bench for interval_fill with a small table-driven interval model.
// Clip vectors run only when INTERVAL_FILL_CLIP_EN is defined.
module tb_interval_fill;

  localparam int CORDW = 9;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CORDW-1:0] y_top;
  logic [CORDW-1:0] y_bot;
  logic             busy;
  logic             done;
  logic [CORDW-1:0] query_y;
  logic [CORDW-1:0] s;
  logic [CORDW-1:0] t;
  logic             pix_valid;
  logic             pix_ready;
  logic [CORDW-1:0] pix_x;
  logic [CORDW-1:0] pix_y;

  interval_fill #(.CORDW(CORDW), .H_RES(320)) dut (
    .clk(clk), .rst(rst), .start(start),
    .y_top(y_top), .y_bot(y_bot),
    .busy(busy), .done(done), .query_y(query_y),
    .s(s), .t(t),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int mode;
  int vec;
  int miss;

  // Interval shape model: default is an empty line (s > t).
  always_comb begin
    s = 9'd1;
    t = 9'd0;
    case (mode)
      1: if (query_y >= 9'd20 && query_y <= 9'd22) begin s = 9'd10; t = 9'd12; end
      2: if (query_y == 9'd6) begin s = 9'd3; t = 9'd3; end
      3: if (query_y == 9'd40) begin s = 9'd100; t = 9'd103; end
      4: if (query_y == 9'd511) begin s = 9'd510; t = 9'd511; end
      5: if (query_y == 9'd1) begin s = 9'd316; t = 9'd400; end
         else if (query_y == 9'd2) begin s = 9'd330; t = 9'd340; end
      6: if (query_y == 9'd9) begin s = 9'd50; t = 9'd54; end
      default: ;
    endcase
  end

  int px[$];
  int py[$];
  int done_c;
  int firstv;
  int q1;
  int busy_after;
  int done_after;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vec++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a fill and collect handshakes until one cycle past done.
  task automatic run(input int yt, input int yb, input int rmode, input int ign);
    bit hold;
    int hx;
    int hy;
    px.delete();
    py.delete();
    done_c = -1;
    firstv = -1;
    q1 = -1;
    busy_after = -1;
    done_after = -1;
    hold = 1'b0;
    hx = 0;
    hy = 0;
    y_top = CORDW'(yt);
    y_bot = CORDW'(yb);
    start = 1'b1;
    pix_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 300; c++) begin
      if (c == 1) q1 = int'(query_y);
      pix_ready = (rmode == 0) ? 1'b1 : ((c % 2) == 1);
      if (ign != 0 && c == 3) begin
        start = 1'b1;
        y_top = '0;
        y_bot = '0;
      end
      if (ign != 0 && c == 4) start = 1'b0;
      if (hold) begin
        chk("hold_valid", int'(pix_valid), 1);
        chk("hold_x", int'(pix_x), hx);
        chk("hold_y", int'(pix_y), hy);
      end
      hold = pix_valid && !pix_ready;
      hx = int'(pix_x);
      hy = int'(pix_y);
      if (pix_valid && firstv < 0) firstv = c;
      if (pix_valid && pix_ready) begin
        px.push_back(int'(pix_x));
        py.push_back(int'(pix_y));
      end
      if (done_c >= 0) begin
        busy_after = int'(busy);
        done_after = int'(done);
        break;
      end
      if (done) done_c = c;
      tick();
    end
    start = 1'b0;
    pix_ready = 1'b1;
    if (done_c < 0) chk("timeout_done", 0, 1);
  endtask

  initial begin
    vec = 0;
    miss = 0;
    mode = 0;
    rst = 1'b1;
    start = 1'b0;
    y_top = '0;
    y_bot = '0;
    pix_ready = 1'b1;
    tick();
    tick();

    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(pix_valid), 0);
    chk("rst_query_y", int'(query_y), 0);
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_pix_y", int'(pix_y), 0);
    rst = 1'b0;
    tick();

    // Square span with a start pulse injected while busy.
    mode = 1;
    run(20, 22, 0, 1);
    chk("sq_count", px.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk("sq_x", px[i], 10 + (i % 3));
      chk("sq_y", py[i], 20 + (i / 3));
    end
    chk("sq_query_y", q1, 20);
    chk("sq_first_valid", firstv, 2);
    chk("sq_done_cycle", done_c, 13);
    chk("sq_busy_after", busy_after, 0);
    chk("sq_done_pulse", done_after, 0);

    // Empty line followed by a single pixel line.
    mode = 2;
    run(5, 6, 0, 0);
    chk("emp_count", px.size(), 1);
    chk("emp_x", px[0], 3);
    chk("emp_y", py[0], 6);
    chk("emp_first_valid", firstv, 3);
    chk("emp_done_cycle", done_c, 4);

    // Backpressure: ready toggles, span of 4.
    mode = 3;
    run(40, 40, 1, 0);
    chk("bp_count", px.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_x", px[i], 100 + i);
      chk("bp_y", py[i], 40);
    end
    chk("bp_done_cycle", done_c, 10);

    // Degenerate range.
    mode = 1;
    run(7, 6, 0, 0);
    chk("deg_count", px.size(), 0);
    chk("deg_first_valid", firstv, -1);
    chk("deg_done_cycle", done_c, 1);
    chk("deg_busy_after", busy_after, 0);

`ifdef INTERVAL_FILL_CLIP_EN
    // Clipped span and fully off-screen span.
    mode = 5;
    run(1, 2, 0, 0);
    chk("clip_count", px.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("clip_x", px[i], 316 + i);
      chk("clip_y", py[i], 1);
    end
    chk("clip_done_cycle", done_c, 7);
`else
    // Span and line at the top of the coordinate range.
    mode = 4;
    run(511, 511, 0, 0);
    chk("wrap_count", px.size(), 2);
    chk("wrap_x0", px[0], 510);
    chk("wrap_x1", px[1], 511);
    chk("wrap_y", py[1], 511);
    chk("wrap_done_cycle", done_c, 4);
    chk("wrap_busy_after", busy_after, 0);
`endif

    // Reset during the second pixel of a 5-pixel span.
    mode = 6;
    y_top = 9'd9;
    y_bot = 9'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_pix1_x", int'(pix_x), 50);
    tick();
    chk("mid_pix2_x", int'(pix_x), 51);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(pix_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    run(9, 9, 0, 0);
    chk("post_count", px.size(), 5);
    chk("post_x0", px[0], 50);
    chk("post_x4", px[4], 54);
    chk("post_y", py[0], 9);
    chk("post_done_cycle", done_c, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
